// File: rtl/qmca_seq_if.sv
// rtl/qmca_seq_if.sv - front-end/readout handshake bundle for the QMCA acquisition sequencer
interface qmca_seq_if #(
    parameter int CH_W = 2
);
    logic            comp;
    logic            rd_ack;
    logic            sm_collect;
    logic            sm_data;
    logic [CH_W-1:0] sm_channel;

    modport master (
        input  comp,
        input  rd_ack,
        output sm_collect,
        output sm_data,
        output sm_channel
    );

    modport slave (
        output comp,
        output rd_ack,
        input  sm_collect,
        input  sm_data,
        input  sm_channel
    );
endinterface

// File: rtl/qmca_seq.sv
// rtl/qmca_seq.sv - QMCA acquisition sequencer; QMCA_SEQ_TIMEOUT_EN adds a sticky readout watchdog
module qmca_seq #(
    parameter int CH_W   = 2,
    parameter int PRE_W  = 10,
    parameter int EVT_W  = 10,
    parameter int HOLD_W = 8,
    parameter int CNT_W  = 16,
    parameter int TO_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [CH_W-1:0]    sel_channel,
    input  logic [PRE_W-1:0]   pre_len,
    input  logic [EVT_W-1:0]   evt_len,
    input  logic [HOLD_W-1:0]  holdoff,
    qmca_seq_if.master         bus,
    output logic [CNT_W-1:0]   trig_cnt,
    output logic               busy,
    output logic               timeout_err,
    output logic [4:0]         state
);

    // One shared phase counter: wide enough for the readout word total and the holdoff length.
    localparam int WD_W = ((PRE_W > EVT_W) ? PRE_W : EVT_W) + 1;
    localparam int CW   = (WD_W > HOLD_W) ? WD_W : HOLD_W;

    typedef enum logic [4:0] {
        S_BUFFER  = 5'b00001,
        S_IDLE    = 5'b00010,
        S_EVENT   = 5'b00100,
        S_READOUT = 5'b01000,
        S_HOLDOFF = 5'b10000
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [PRE_W-1:0]   pre_l_q, pre_l_d;
    logic [EVT_W-1:0]   evt_l_q, evt_l_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [CNT_W-1:0]   trig_q, trig_d;
    logic               collect_q, collect_d;
    logic               data_q, data_d;
    logic               busy_q, busy_d;

    logic [CW-1:0]      cnt_inc;
    logic [CW-1:0]      pre_eff;
    logic [CW-1:0]      evt_eff;
    logic [CW-1:0]      hold_eff;
    logic [CW-1:0]      words;

    assign cnt_inc  = cnt_q + CW'(1);
    assign pre_eff  = (pre_len == '0) ? CW'(1) : CW'(pre_len);
    assign evt_eff  = (evt_l_q == '0) ? CW'(1) : CW'(evt_l_q);
    assign hold_eff = (holdoff == '0) ? CW'(1) : CW'(holdoff);
    assign words    = CW'(pre_l_q) + evt_eff;

`ifdef QMCA_SEQ_TIMEOUT_EN
    logic [TO_W-1:0]    wd_q, wd_d;
    logic [TO_W-1:0]    wd_inc;
    logic               err_q, err_d;

    assign wd_inc      = wd_q + TO_W'(1);
    assign timeout_err = err_q;
`else
    logic [TO_W-1:0]    unused_to_w;

    assign unused_to_w = '0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pre_l_d = pre_l_q;
        evt_l_d = evt_l_q;
        ch_d    = ch_q;
        trig_d  = trig_q;
`ifdef QMCA_SEQ_TIMEOUT_EN
        wd_d    = '0;
        err_d   = err_q;
`endif
        case (state_q)
            S_BUFFER: begin
                // pre_len is live here, so >= lets a shrinking length end the fill at once.
                if (enable) begin
                    if (cnt_inc >= pre_eff) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end
            end
            S_IDLE: begin
                cnt_d = '0;
                if (!enable) begin
                    state_d = S_BUFFER;
                end else if (bus.comp) begin
                    state_d = S_EVENT;
                    ch_d    = sel_channel;
                    pre_l_d = pre_len;
                    evt_l_d = evt_len;
                    if (trig_q != '1) begin
                        trig_d = trig_q + CNT_W'(1);
                    end
                end
            end
            S_EVENT: begin
                if (cnt_inc >= evt_eff) begin
                    state_d = S_READOUT;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_inc;
                end
            end
            S_READOUT: begin
                if (bus.rd_ack) begin
                    if (cnt_inc >= words) begin
                        state_d = S_HOLDOFF;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end
`ifdef QMCA_SEQ_TIMEOUT_EN
                else if (wd_inc == '1) begin
                    state_d = S_HOLDOFF;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    wd_d    = wd_inc;
                end
`endif
            end
            S_HOLDOFF: begin
                if (cnt_inc >= hold_eff) begin
                    state_d = S_BUFFER;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_inc;
                end
            end
            default: begin
                state_d = S_BUFFER;
                cnt_d   = '0;
            end
        endcase

        collect_d = (state_d == S_EVENT);
        data_d    = (state_d == S_READOUT);
        busy_d    = (state_d == S_EVENT) || (state_d == S_READOUT) || (state_d == S_HOLDOFF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_BUFFER;
            cnt_q     <= '0;
            pre_l_q   <= '0;
            evt_l_q   <= '0;
            ch_q      <= '0;
            trig_q    <= '0;
            collect_q <= 1'b0;
            data_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef QMCA_SEQ_TIMEOUT_EN
            wd_q      <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pre_l_q   <= pre_l_d;
            evt_l_q   <= evt_l_d;
            ch_q      <= ch_d;
            trig_q    <= trig_d;
            collect_q <= collect_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
`ifdef QMCA_SEQ_TIMEOUT_EN
            wd_q      <= wd_d;
            err_q     <= err_d;
`endif
        end
    end

    assign bus.sm_collect = collect_q;
    assign bus.sm_data    = data_q;
    assign bus.sm_channel = ch_q;
    assign trig_cnt       = trig_q;
    assign busy           = busy_q;
    assign state          = state_q;

endmodule

// File: tb/tb_qmca_seq.sv
// tb/tb_qmca_seq.sv - directed and randomized bench for qmca_seq against a phase/budget reference model
module tb_qmca_seq;
    localparam int CH_W   = 2;
    localparam int PRE_W  = 10;
    localparam int EVT_W  = 10;
    localparam int HOLD_W = 8;
    localparam int CNT_W  = 2;
    localparam int TO_W   = 4;
    localparam int TRIG_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              enable = 1'b0;
    logic [CH_W-1:0]   sel_channel = '0;
    logic [PRE_W-1:0]  pre_len = '0;
    logic [EVT_W-1:0]  evt_len = '0;
    logic [HOLD_W-1:0] holdoff = '0;
    logic [CNT_W-1:0]  trig_cnt;
    logic              busy;
    logic              timeout_err;
    logic [4:0]        state;

    qmca_seq_if #(.CH_W(CH_W)) bus ();

    qmca_seq #(
        .CH_W(CH_W), .PRE_W(PRE_W), .EVT_W(EVT_W),
        .HOLD_W(HOLD_W), .CNT_W(CNT_W), .TO_W(TO_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .sel_channel(sel_channel),
        .pre_len(pre_len),
        .evt_len(evt_len),
        .holdoff(holdoff),
        .bus(bus),
        .trig_cnt(trig_cnt),
        .busy(busy),
        .timeout_err(timeout_err),
        .state(state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase index 0..4 = BUFFER, IDLE, EVENT, READOUT, HOLDOFF.
    int m_ph, m_fill, m_rem, m_wd, m_ch, m_pre, m_evt, m_trig, m_err;

    function automatic int at_least_one(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_fill = 0; m_rem = 0; m_wd = 0;
        m_ch = 0; m_pre = 0; m_evt = 0; m_trig = 0; m_err = 0;
    endtask

    task automatic enter_holdoff();
        m_ph  = 4;
        m_rem = at_least_one(int'(holdoff));
    endtask

    task automatic model_step();
        case (m_ph)
            0: if (enable) begin
                m_fill++;
                if (m_fill >= at_least_one(int'(pre_len))) begin
                    m_ph = 1; m_fill = 0;
                end
            end
            1: if (!enable) begin
                m_ph = 0; m_fill = 0;
            end else if (bus.comp) begin
                m_ph   = 2;
                m_ch   = int'(sel_channel);
                m_pre  = int'(pre_len);
                m_evt  = int'(evt_len);
                m_trig = (m_trig < TRIG_MAX) ? m_trig + 1 : TRIG_MAX;
                m_rem  = at_least_one(m_evt);
            end
            2: begin
                m_rem--;
                if (m_rem == 0) begin
                    m_ph = 3; m_rem = m_pre + at_least_one(m_evt); m_wd = 0;
                end
            end
            3: if (bus.rd_ack) begin
                m_wd = 0;
                m_rem--;
                if (m_rem == 0) enter_holdoff();
            end else begin
`ifdef QMCA_SEQ_TIMEOUT_EN
                m_wd++;
                if (m_wd == (1 << TO_W) - 1) begin
                    m_err = 1;
                    enter_holdoff();
                end
`endif
            end
            default: begin
                m_rem--;
                if (m_rem == 0) begin
                    m_ph = 0; m_fill = 0;
                end
            end
        endcase
    endtask

    task automatic check_all();
        check("state", state, 32'(1 << m_ph));
        check("sm_collect", bus.sm_collect, m_ph == 2);
        check("sm_data", bus.sm_data, m_ph == 3);
        check("busy", busy, m_ph >= 2);
        check("sm_channel", bus.sm_channel, m_ch);
        check("trig_cnt", trig_cnt, m_trig);
        check("timeout_err", timeout_err, m_err);
    endtask

    task automatic cyc(input bit en, input bit c, input bit a);
        enable     = en;
        bus.comp   = c;
        bus.rd_ack = a;
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        bus.comp   = 1'b0;
        bus.rd_ack = 1'b0;
        do_reset();
        check("rst_state", state, 5'b00001);

        // Pre-trigger fill of 4 enabled cycles.
        pre_len = 10'd4; evt_len = 10'd8; holdoff = 8'd3; sel_channel = 2'd2;
        repeat (3) cyc(1, 0, 0);
        check("fill_hold", state, 5'b00001);
        cyc(1, 0, 0);
        check("fill_done", state, 5'b00010);

        // Trigger, then 8 collect cycles with comp and input changes ignored.
        cyc(1, 1, 0);
        check("trig_ch", bus.sm_channel, 2);
        check("trig_first", trig_cnt, 1);
        sel_channel = 2'd1; evt_len = 10'd3;
        repeat (7) cyc(1, 1, 0);
        check("evt_still", bus.sm_collect, 1);
        cyc(1, 0, 0);
        check("readout_grant", bus.sm_data, 1);

        // 12 words with gaps, enable dropped during readout.
        for (int k = 0; k < 12; k++) begin
            cyc(0, 0, 0);
            cyc(0, 0, 1);
        end
        check("holdoff_entry", state, 5'b10000);
        repeat (2) cyc(0, 1, 0);
        check("holdoff_last", state, 5'b10000);
        cyc(0, 1, 0);
        check("refill", state, 5'b00001);
        repeat (5) cyc(0, 1, 0);
        check("held_buffer", state, 5'b00001);
        repeat (4) cyc(1, 0, 0);
        check("refill_done", state, 5'b00010);
        check("no_extra_trig", trig_cnt, 1);

        // Disable wins over a simultaneous trigger.
        cyc(0, 1, 0);
        check("disable_wins", trig_cnt, 1);
        pre_len = '0; evt_len = '0; holdoff = '0;
        cyc(1, 0, 0);

        // Saturating count with minimal lengths everywhere.
        for (int t = 0; t < 4; t++) begin
            cyc(1, 1, 0);
            check("sat_cnt", trig_cnt, (t == 0) ? 2 : 3);
            cyc(1, 0, 0);
            check("evt_one", state, 5'b01000);
            cyc(1, 0, 1);
            check("hold_one", state, 5'b10000);
            cyc(1, 0, 0);
            cyc(1, 0, 0);
            check("back_idle", state, 5'b00010);
        end

        // Asynchronous reset in the middle of readout.
        cyc(1, 1, 0);
        cyc(1, 0, 0);
        check("pre_reset_rd", bus.sm_data, 1);
        do_reset();
        check("reset_trig", trig_cnt, 0);

`ifdef QMCA_SEQ_TIMEOUT_EN
        cyc(1, 0, 0);
        cyc(1, 1, 0);
        cyc(1, 0, 0);
        repeat (14) cyc(1, 0, 0);
        check("wd_waiting", state, 5'b01000);
        cyc(1, 0, 0);
        check("wd_fire", state, 5'b10000);
        check("wd_err", timeout_err, 1);
        repeat (5) cyc(1, 0, 0);
        check("wd_sticky", timeout_err, 1);
        do_reset();
        check("wd_cleared", timeout_err, 0);
`endif

        // Randomized traffic; lengths only change where they cannot alter a running phase.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                sel_channel = CH_W'($urandom);
                evt_len     = EVT_W'($urandom_range(0, 6));
                if (m_ph != 0) pre_len = PRE_W'($urandom_range(0, 5));
                if (m_ph != 4) holdoff = HOLD_W'($urandom_range(0, 4));
                cyc($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/qmca_seq.md
Name: qmca_seq

Overview:
- Parametrised acquisition sequencer for the QMCA channel front end. Successor to the fixed 4-state controller.
- Adds programmable pre-trigger fill, event length, holdoff and readout word counting, so no external full/empty flags are needed.
- Adds a configurable channel-select width, an enable gate and a saturating trigger counter.
- Sits between the comparator/ring buffer and the readout FIFO, granting collect and data phases.

Parameters:
- CH_W, 2, width of channel select
- PRE_W, 10, width of pre-trigger length
- EVT_W, 10, width of event length
- HOLD_W, 8, width of holdoff length
- CNT_W, 16, width of trigger counter
- TO_W, 16, width of readout watchdog counter (used only with the optional feature)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  arm sequencer
- sel_channel  in  CH_W  requested channel
- pre_len  in  PRE_W  pre-trigger samples to buffer
- evt_len  in  EVT_W  samples to collect per event
- holdoff  in  HOLD_W  dead cycles after readout
- comp  in  1  trigger from comparator
- rd_ack  in  1  one readout word consumed
- sm_collect  out  1  collect grant (EVENT)
- sm_data  out  1  readout grant (READOUT)
- sm_channel  out  CH_W  channel latched at trigger
- trig_cnt  out  CNT_W  accepted triggers, saturating
- busy  out  1  high in EVENT, READOUT, HOLDOFF
- timeout_err  out  1  sticky readout watchdog flag
- state  out  5  one-hot debug state

Behaviour:
- Reset (rst_n low, async) forces:
  - state = BUFFER, all counters 0.
  - sm_collect = sm_data = busy = timeout_err = 0, sm_channel = 0, trig_cnt = 0.
- All outputs are registered; each one reflects the current state.
- State encoding: BUFFER=00001, IDLE=00010, EVENT=00100, READOUT=01000, HOLDOFF=10000. Any illegal code goes to BUFFER on the next edge.
- BUFFER:
  - Counts cycles while enable=1; the count holds while enable=0.
  - Goes to IDLE after max(pre_len,1) enabled cycles.
  - pre_len is sampled continuously while in BUFFER.
- IDLE:
  - If enable=0, goes to BUFFER and the counter clears.
  - Else if comp=1, goes to EVENT on the next edge. On that same edge it latches sel_channel into sm_channel, latches pre_len and evt_len, and increments trig_cnt (no wrap at all-ones).
  - comp in any other state is ignored.
- EVENT:
  - sm_collect=1 for exactly max(evt_len,1) cycles, then READOUT.
  - Changes to lengths or channel mid-event have no effect.
- READOUT:
  - sm_data=1 from the first READOUT cycle.
  - Each cycle with rd_ack=1 counts one word. Words expected = latched pre_len + max(evt_len,1), counted in PRE_W+1 or EVT_W+1 bits, whichever is wider.
  - On the edge that counts the final word, goes to HOLDOFF (sm_data drops the next cycle).
  - rd_ack outside READOUT is ignored.
- HOLDOFF:
  - Lasts holdoff cycles, then BUFFER (pre-trigger refill).
  - holdoff=0 means a single HOLDOFF cycle.
- enable=0 during EVENT, READOUT or HOLDOFF does not abort. The sequence completes, then the block holds in BUFFER.
- Simultaneous comp and enable=0 in IDLE: the disable wins, no trigger is counted.

Optional Feature:
- Macro QMCA_SEQ_TIMEOUT_EN.
- With the macro:
  - A TO_W watchdog counts READOUT cycles since the last rd_ack, or since READOUT entry.
  - At 2^TO_W-1 cycles it forces HOLDOFF and sets timeout_err.
  - timeout_err is cleared only by reset.
- Without the macro: no watchdog logic, timeout_err tied 0, READOUT waits indefinitely.

Test Plan:
1. Reset then enable=1, pre_len=4 -> state 00001 for 4 cycles, then 00010. All outputs 0 during and after reset.
2. IDLE with sel_channel=2, evt_len=8, comp pulse -> sm_channel=2, trig_cnt=1, sm_collect high exactly 8 cycles, then sm_data=1.
3. READOUT with pre_len=4, evt_len=8, 12 rd_ack pulses with gaps -> sm_data drops after the 12th. holdoff=3 gives 3 HOLDOFF cycles, then BUFFER 4 cycles, then IDLE.
4. comp asserted during EVENT/HOLDOFF; enable=0 during READOUT -> no extra trig_cnt; sequence completes, then holds in BUFFER until enable=1.
5. CNT_W=2, 5 triggers -> trig_cnt reads 1,2,3,3,3. evt_len=0 and holdoff=0 -> 1-cycle EVENT and 1-cycle HOLDOFF.
6. With QMCA_SEQ_TIMEOUT_EN, TO_W=4, no rd_ack -> HOLDOFF after 15 READOUT cycles, timeout_err=1 until rst_n low. Mid-READOUT rst_n low -> immediate BUFFER, all outputs 0.
